// File: rtl/ac_compressor_sequencer.sv
// ac_compressor_sequencer
//
// Sequences the climate unit's compressor, heater and fan from periodic
// temperature samples compared against a signed setpoint with hysteresis.
// The fan leads and trails every compressor/heater run. A minimum run time
// and a minimum off time prevent short-cycling.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-low reset
//   enable        1 = automatic control permitted
//   setpoint      signed target temperature (TEMP_W bits)
//   sensor_req    sample request, held high until sensor_valid
//   sensor_valid  one-cycle strobe, sensor_temp valid
//   sensor_temp   signed sample (TEMP_W bits)
//   cool_on       compressor drive
//   heat_on       heater drive
//   fan_on        fan drive
//   state_o       current FSM state encoding
//   temp_latched  last accepted sample
//
// Optional build macro ACSEQ_STATUS_LED_EN adds the blueLED/greenLED/redLED
// status outputs. They follow the state one cycle later.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | 0: all off, waiting for a cool or heat demand
// FAN_PRE  | 1: fan alone for FAN_LEAD cycles before compressor/heater
// COOL     | 2: compressor + fan, at least MIN_RUN cycles
// HEAT     | 3: heater + fan, at least MIN_RUN cycles
// FAN_POST | 4: fan alone for FAN_TAIL cycles after the run
// LOCKOUT  | 5: all off for MIN_OFF cycles, demand ignored
module ac_compressor_sequencer #(
    parameter int TEMP_W        = 8,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int HYST          = 2,
    parameter int FAN_LEAD      = 50,
    parameter int FAN_TAIL      = 100,
    parameter int MIN_RUN       = 500,
    parameter int MIN_OFF       = 300
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [TEMP_W-1:0] setpoint,
    output logic              sensor_req,
    input  logic              sensor_valid,
    input  logic [TEMP_W-1:0] sensor_temp,
    output logic              cool_on,
    output logic              heat_on,
    output logic              fan_on,
    output logic [2:0]        state_o,
    output logic [TEMP_W-1:0] temp_latched
`ifdef ACSEQ_STATUS_LED_EN
    ,
    output logic              blueLED,
    output logic              greenLED,
    output logic              redLED
`endif
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FAN_PRE  = 3'd1,
        S_COOL     = 3'd2,
        S_HEAT     = 3'd3,
        S_FAN_POST = 3'd4,
        S_LOCKOUT  = 3'd5
    } state_t;

    localparam int TMR_W   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int MAX_A   = (FAN_LEAD > FAN_TAIL) ? FAN_LEAD : FAN_TAIL;
    localparam int MAX_B   = (MIN_RUN > MIN_OFF) ? MIN_RUN : MIN_OFF;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [TMR_W-1:0] TMR_LD  = TMR_W'(SAMPLE_PERIOD - 1);
    localparam logic [CNT_W-1:0] LEAD_LD = CNT_W'(FAN_LEAD - 1);
    localparam logic [CNT_W-1:0] TAIL_LD = CNT_W'(FAN_TAIL - 1);
    localparam logic [CNT_W-1:0] RUN_LD  = CNT_W'(MIN_RUN - 1);
    localparam logic [CNT_W-1:0] OFF_LD  = CNT_W'(MIN_OFF - 1);
    localparam logic signed [TEMP_W:0] HYST_X = (TEMP_W + 1)'(HYST);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               mode_cool_q, mode_cool_d;
    logic               sensor_req_q, sensor_req_d;
    logic               temp_valid_q, temp_valid_d;
    logic [TEMP_W-1:0]  temp_latched_q, temp_latched_d;
    logic               cool_on_q, cool_on_d;
    logic               heat_on_q, heat_on_d;
    logic               fan_on_q, fan_on_d;
`ifdef ACSEQ_STATUS_LED_EN
    logic               blue_led_q, blue_led_d;
    logic               green_led_q, green_led_d;
    logic               red_led_q, red_led_d;
`endif

    // One extra bit keeps setpoint +/- HYST from wrapping at the range ends.
    logic signed [TEMP_W:0] temp_x;
    logic signed [TEMP_W:0] sp_x;
    logic                   cool_dem;
    logic                   heat_dem;
    logic                   cool_sat;
    logic                   heat_sat;
    logic                   run_sat;

    always_comb begin
        temp_x   = {temp_latched_q[TEMP_W-1], temp_latched_q};
        sp_x     = {setpoint[TEMP_W-1], setpoint};
        cool_dem = temp_valid_q && (temp_x > (sp_x + HYST_X));
        heat_dem = temp_valid_q && (temp_x < (sp_x - HYST_X));
        cool_sat = (temp_x <= sp_x);
        heat_sat = (temp_x >= sp_x);
        run_sat  = (state_q == S_COOL) ? cool_sat : heat_sat;
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        tmr_d          = tmr_q;
        mode_cool_d    = mode_cool_q;
        sensor_req_d   = sensor_req_q;
        temp_valid_d   = temp_valid_q;
        temp_latched_d = temp_latched_q;

        // Sampler: the period timer only runs while no request is pending.
        if (sensor_req_q) begin
            if (sensor_valid) begin
                temp_latched_d = sensor_temp;
                temp_valid_d   = 1'b1;
                sensor_req_d   = 1'b0;
                tmr_d          = TMR_LD;
            end
        end else if (tmr_q == '0) begin
            sensor_req_d = 1'b1;
        end else begin
            tmr_d = tmr_q - TMR_W'(1);
        end

        // Each timed state loads cnt with (length - 1) on entry and leaves
        // on terminal count, so it occupies exactly 'length' cycles.
        case (state_q)
            S_IDLE: begin
                if (enable && cool_dem) begin
                    state_d     = S_FAN_PRE;
                    mode_cool_d = 1'b1;
                    cnt_d       = LEAD_LD;
                end else if (enable && heat_dem) begin
                    state_d     = S_FAN_PRE;
                    mode_cool_d = 1'b0;
                    cnt_d       = LEAD_LD;
                end
            end
            S_FAN_PRE: begin
                if (!enable) begin
                    state_d = S_FAN_POST;
                    cnt_d   = TAIL_LD;
                end else if (cnt_q == '0) begin
                    state_d = mode_cool_q ? S_COOL : S_HEAT;
                    cnt_d   = RUN_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_COOL, S_HEAT: begin
                // cnt sticks at zero once MIN_RUN has elapsed; from then on
                // the run ends as soon as it is satisfied or disabled.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (run_sat || !enable) begin
                    state_d = S_FAN_POST;
                    cnt_d   = TAIL_LD;
                end
            end
            S_FAN_POST: begin
                if (cnt_q == '0) begin
                    state_d = S_LOCKOUT;
                    cnt_d   = OFF_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_LOCKOUT: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state and registered, so they
        // always match the registered state exactly and never glitch.
        cool_on_d = (state_d == S_COOL);
        heat_on_d = (state_d == S_HEAT);
        fan_on_d  = (state_d == S_FAN_PRE) || (state_d == S_COOL) ||
                    (state_d == S_HEAT) || (state_d == S_FAN_POST);

`ifdef ACSEQ_STATUS_LED_EN
        blue_led_d  = (state_q == S_COOL);
        red_led_d   = (state_q == S_HEAT);
        green_led_d = (state_q == S_IDLE) && temp_valid_q;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            tmr_q          <= TMR_LD;
            mode_cool_q    <= 1'b0;
            sensor_req_q   <= 1'b0;
            temp_valid_q   <= 1'b0;
            temp_latched_q <= '0;
            cool_on_q      <= 1'b0;
            heat_on_q      <= 1'b0;
            fan_on_q       <= 1'b0;
`ifdef ACSEQ_STATUS_LED_EN
            blue_led_q     <= 1'b0;
            green_led_q    <= 1'b0;
            red_led_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tmr_q          <= tmr_d;
            mode_cool_q    <= mode_cool_d;
            sensor_req_q   <= sensor_req_d;
            temp_valid_q   <= temp_valid_d;
            temp_latched_q <= temp_latched_d;
            cool_on_q      <= cool_on_d;
            heat_on_q      <= heat_on_d;
            fan_on_q       <= fan_on_d;
`ifdef ACSEQ_STATUS_LED_EN
            blue_led_q     <= blue_led_d;
            green_led_q    <= green_led_d;
            red_led_q      <= red_led_d;
`endif
        end
    end

    assign sensor_req   = sensor_req_q;
    assign cool_on      = cool_on_q;
    assign heat_on      = heat_on_q;
    assign fan_on       = fan_on_q;
    assign state_o      = state_q;
    assign temp_latched = temp_latched_q;
`ifdef ACSEQ_STATUS_LED_EN
    assign blueLED      = blue_led_q;
    assign greenLED     = green_led_q;
    assign redLED       = red_led_q;
`endif

endmodule

// File: tb/tb_ac_compressor_sequencer.sv
// Testbench for ac_compressor_sequencer (small timing parameters).
module tb_ac_compressor_sequencer;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FAN_PRE  = 3'd1;
    localparam logic [2:0] ST_COOL     = 3'd2;
    localparam logic [2:0] ST_HEAT     = 3'd3;
    localparam logic [2:0] ST_FAN_POST = 3'd4;
    localparam logic [2:0] ST_LOCKOUT  = 3'd5;

    logic       clk          = 1'b0;
    logic       reset        = 1'b0;
    logic       enable       = 1'b1;
    logic [7:0] setpoint     = 8'd22;
    logic       sensor_valid = 1'b0;
    logic [7:0] sensor_temp  = 8'd0;
    logic       sensor_req;
    logic       cool_on;
    logic       heat_on;
    logic       fan_on;
    logic [2:0] state_o;
    logic [7:0] temp_latched;

    always #5 clk = ~clk;

    ac_compressor_sequencer #(
        .TEMP_W        (8),
        .SAMPLE_PERIOD (8),
        .HYST          (2),
        .FAN_LEAD      (4),
        .FAN_TAIL      (6),
        .MIN_RUN       (20),
        .MIN_OFF       (10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .setpoint     (setpoint),
        .sensor_req   (sensor_req),
        .sensor_valid (sensor_valid),
        .sensor_temp  (sensor_temp),
        .cool_on      (cool_on),
        .heat_on      (heat_on),
        .fan_on       (fan_on),
        .state_o      (state_o),
        .temp_latched (temp_latched)
    );

    typedef struct {
        logic [2:0] st;
        int         len;   // expected cycles in state, 0 = not checked
    } seg_t;

    seg_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic push_seg(input logic [2:0] st, input int len);
        seg_t s;
        s.st  = st;
        s.len = len;
        exp_q.push_back(s);
    endtask

    // Scoreboard monitor: each state change pops the next expected segment;
    // segment lengths and per-state actuator outputs are compared.
    logic       mon_en    = 1'b0;
    logic [2:0] mon_state = ST_IDLE;
    logic [2:0] exp_st    = ST_IDLE;
    int         mon_cnt   = 0;
    int         mon_len   = 0;

    always @(negedge clk) begin
        seg_t s;
        if (mon_en) begin
            if (state_o != mon_state) begin
                if (mon_len != 0)
                    chk("seg_len", 32'(mon_cnt), 32'(mon_len));
                if (exp_q.size() == 0) begin
                    chk("unexpected_state", 32'(state_o), 32'(mon_state));
                end else begin
                    s = exp_q.pop_front();
                    chk("next_state", 32'(state_o), 32'(s.st));
                    exp_st  = s.st;
                    mon_len = s.len;
                end
                mon_state = state_o;
                mon_cnt   = 1;
            end else begin
                mon_cnt++;
            end
            chk("cool_on", 32'(cool_on), 32'(exp_st == ST_COOL));
            chk("heat_on", 32'(heat_on), 32'(exp_st == ST_HEAT));
            chk("fan_on", 32'(fan_on),
                32'((exp_st == ST_FAN_PRE) || (exp_st == ST_COOL) ||
                    (exp_st == ST_HEAT) || (exp_st == ST_FAN_POST)));
        end else begin
            mon_state = ST_IDLE;
            exp_st    = ST_IDLE;
            mon_cnt   = 0;
            mon_len   = 0;
        end
    end

    // Sensor model: answers 3 cycles after seeing the request.
    task automatic give_sample(input logic [7:0] t);
        int n;
        n = 0;
        while (!sensor_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", 32'(sensor_req), 32'd1);
        if (sensor_req) begin
            repeat (3) @(negedge clk);
            sensor_valid = 1'b1;
            sensor_temp  = t;
            @(negedge clk);
            sensor_valid = 1'b0;
            chk("temp_latched", 32'(temp_latched), 32'(t));
            chk("req_drop", 32'(sensor_req), 32'd0);
        end
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state_o), 32'(ST_IDLE));
        chk("rst_act", 32'({cool_on, heat_on, fan_on}), 32'd0);
        chk("rst_req", 32'(sensor_req), 32'd0);
        chk("rst_temp", 32'(temp_latched), 32'd0);
        reset  = 1'b1;
        mon_en = 1'b1;

        // First request after SAMPLE_PERIOD cycles, nothing runs before it.
        n = 0;
        while (!sensor_req && n < 50) begin
            @(negedge clk);
            n++;
            chk("no_act_pre_sample", 32'({cool_on, heat_on, fan_on}), 32'd0);
        end
        chk("first_req_cycle", 32'(n), 32'd8);
        repeat (3) @(negedge clk);
        sensor_valid = 1'b1;
        sensor_temp  = 8'd22;
        @(negedge clk);
        chk("temp_latched", 32'(temp_latched), 32'd22);
        chk("req_drop", 32'(sensor_req), 32'd0);
        // A strobe with no request pending must be ignored.
        sensor_temp = 8'd99;
        @(negedge clk);
        sensor_valid = 1'b0;
        chk("ignore_valid", 32'(temp_latched), 32'd22);
        n = 1;
        while (!sensor_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("next_req_cycle", 32'(n), 32'd8);

        // Cooling run: satisfied early but held for MIN_RUN.
        push_seg(ST_FAN_PRE, 4);
        push_seg(ST_COOL, 20);
        push_seg(ST_FAN_POST, 6);
        push_seg(ST_LOCKOUT, 10);
        push_seg(ST_IDLE, 0);
        give_sample(8'd26);
        give_sample(8'd21);
        wait_drain(200);

        // Inside the hysteresis band at both edges: no action.
        give_sample(8'd24);
        give_sample(8'd20);
        repeat (10) @(negedge clk);
        chk("band_idle", 32'(state_o), 32'(ST_IDLE));

        // Heating run.
        push_seg(ST_FAN_PRE, 4);
        push_seg(ST_HEAT, 20);
        push_seg(ST_FAN_POST, 6);
        push_seg(ST_LOCKOUT, 10);
        push_seg(ST_IDLE, 0);
        give_sample(8'd19);
        give_sample(8'd23);
        wait_drain(200);

        // Range ends: -128 vs -127-2 and 127 vs 126+2 give no demand.
        enable   = 1'b0;
        setpoint = 8'h81;
        give_sample(8'h80);
        enable = 1'b1;
        repeat (10) @(negedge clk);
        chk("low_end_idle", 32'(state_o), 32'(ST_IDLE));
        enable   = 1'b0;
        setpoint = 8'h7E;
        give_sample(8'h7F);
        enable = 1'b1;
        repeat (10) @(negedge clk);
        chk("high_end_idle", 32'(state_o), 32'(ST_IDLE));

        // Setpoint change acts at once; disable aborts FAN_PRE; the demand
        // is held off through LOCKOUT and restarts right after it.
        push_seg(ST_FAN_PRE, 1);
        push_seg(ST_FAN_POST, 6);
        push_seg(ST_LOCKOUT, 10);
        push_seg(ST_IDLE, 1);
        push_seg(ST_FAN_PRE, 4);
        push_seg(ST_COOL, 0);
        setpoint = 8'd124;
        @(negedge clk);
        chk("sp_immediate", 32'(state_o), 32'(ST_FAN_PRE));
        enable = 1'b0;
        @(negedge clk);
        chk("abort_post", 32'(state_o), 32'(ST_FAN_POST));
        enable = 1'b1;
        wait_drain(100);
        repeat (3) @(negedge clk);
        chk("mid_cool", 32'(state_o), 32'(ST_COOL));

        // Asynchronous reset in the middle of COOL.
        mon_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_act", 32'({cool_on, heat_on, fan_on}), 32'd0);
        chk("arst_state", 32'(state_o), 32'(ST_IDLE));
        chk("arst_req", 32'(sensor_req), 32'd0);
        chk("arst_temp", 32'(temp_latched), 32'd0);
        exp_q.delete();
        setpoint = 8'd22;
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
        // temp_latched=0 is far below the band; a stale temp_valid would
        // start heating before the first fresh sample.
        n = 0;
        while (!sensor_req && n < 50) begin
            @(negedge clk);
            n++;
            chk("post_rst_idle", 32'(state_o), 32'(ST_IDLE));
        end
        chk("post_rst_req_cycle", 32'(n), 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
